// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response and memory-bus signals of the shared port arbiter.
// master = the arbiter, slave = the core pipeline plus the memory bus model.
interface mem_port_arbiter_if;
  logic        IF_REQ;
  logic [63:0] IF_ADDR;
  logic        IF_DONE;
  logic [31:0] IF_RDATA;
  logic        IF_FAULT;
  logic        MEM_REQ;
  logic [31:0] MEM_IR;
  logic [63:0] MEM_ADDR;
  logic [63:0] MEM_WDATA;
  logic        MEM_DONE;
  logic        MEM_STALL;
  logic [63:0] MEM_RDATA;
  logic        MEM_LAM;
  logic        MEM_LAF;
  logic        MEM_SAM;
  logic        MEM_SAF;
  logic        BUS_REQ;
  logic        BUS_WE;
  logic [63:0] BUS_ADDR;
  logic [7:0]  BUS_WSTRB;
  logic [63:0] BUS_WDATA;
  logic        BUS_ACK;
  logic        BUS_ERR;
  logic [63:0] BUS_RDATA;

  modport master (
    input  IF_REQ, IF_ADDR, MEM_REQ, MEM_IR, MEM_ADDR, MEM_WDATA,
           BUS_ACK, BUS_ERR, BUS_RDATA,
    output IF_DONE, IF_RDATA, IF_FAULT, MEM_DONE, MEM_STALL, MEM_RDATA,
           MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF,
           BUS_REQ, BUS_WE, BUS_ADDR, BUS_WSTRB, BUS_WDATA
  );

  modport slave (
    output IF_REQ, IF_ADDR, MEM_REQ, MEM_IR, MEM_ADDR, MEM_WDATA,
           BUS_ACK, BUS_ERR, BUS_RDATA,
    input  IF_DONE, IF_RDATA, IF_FAULT, MEM_DONE, MEM_STALL, MEM_RDATA,
           MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF,
           BUS_REQ, BUS_WE, BUS_ADDR, BUS_WSTRB, BUS_WDATA
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shared single-port memory bus controller: IF/MEM arbitration, alignment checks,
// store lane steering, load extraction/extension, timeout and fault reporting.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MEM_BURST_MAX  = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  mem_port_arbiter_if.master bus
);
  localparam int GW = $clog2(MEM_BURST_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, DACC, IFETCH, RESP} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_cnt_q, grant_cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [63:0]     bus_addr_q, bus_addr_d;
  logic [7:0]      bus_wstrb_q, bus_wstrb_d;
  logic [63:0]     bus_wdata_q, bus_wdata_d;
  logic [2:0]      ld_off_q, ld_off_d;
  logic [1:0]      ld_sz_q, ld_sz_d;
  logic            ld_uns_q, ld_uns_d;
  logic            if_hi_q, if_hi_d;
  logic            if_done_q, if_done_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic            if_fault_q, if_fault_d;
  logic            mem_done_q, mem_done_d;
  logic [63:0]     mem_rdata_q, mem_rdata_d;
  logic            lam_q, lam_d, laf_q, laf_d, sam_q, sam_d, saf_q, saf_d;

  // MEM request decode
  logic [6:0] opc;
  logic [2:0] f3;
  logic [1:0] sz;
  logic       is_ld, is_st, illegal, misal, mem_pick, xact_end, xact_fault;
  logic [2:0] amask;
  logic [7:0] smask;
  logic       unused_ir;

  assign opc       = bus.MEM_IR[6:0];
  assign f3        = bus.MEM_IR[14:12];
  assign sz        = f3[1:0];
  assign is_ld     = (opc == OP_LOAD);
  assign is_st     = (opc == OP_STORE);
  assign illegal   = is_ld ? (f3 == 3'b111) : f3[2];
  assign misal     = |(bus.MEM_ADDR[2:0] & amask);
  assign unused_ir = ^{bus.MEM_IR[31:15], bus.MEM_IR[11:7]};

  always_comb begin
    amask = 3'b000;
    smask = 8'h01;
    case (sz)
      2'd1:    begin amask = 3'b001; smask = 8'h03; end
      2'd2:    begin amask = 3'b011; smask = 8'h0F; end
      2'd3:    begin amask = 3'b111; smask = 8'hFF; end
      default: begin amask = 3'b000; smask = 8'h01; end
    endcase
  end

  function automatic logic [63:0] load_ext(input logic [63:0] d, input logic [2:0] off,
                                           input logic [1:0] s, input logic uns);
    logic [63:0] sh;
    sh = d >> {off, 3'b000};
    case (s)
      2'd0:    return uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    return uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    return uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  // MEM wins unless IF is waiting and MEM has used up its burst allowance
  assign mem_pick   = bus.MEM_REQ && !(bus.IF_REQ && grant_cnt_q == GW'(MEM_BURST_MAX));
  assign xact_end   = bus.BUS_ACK || bus.BUS_ERR || (tmo_q + TW'(1) == TW'(TIMEOUT_CYCLES));
  assign xact_fault = bus.BUS_ERR || !bus.BUS_ACK;

  always_comb begin
    state_d     = state_q;
    grant_cnt_d = grant_cnt_q;
    tmo_d       = tmo_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    ld_off_d    = ld_off_q;
    ld_sz_d     = ld_sz_q;
    ld_uns_d    = ld_uns_q;
    if_hi_d     = if_hi_q;
    if_done_d   = 1'b0;
    if_rdata_d  = 32'b0;
    if_fault_d  = 1'b0;
    mem_done_d  = 1'b0;
    mem_rdata_d = 64'b0;
    lam_d       = 1'b0;
    laf_d       = 1'b0;
    sam_d       = 1'b0;
    saf_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_pick) begin
          grant_cnt_d = bus.IF_REQ ? grant_cnt_q + GW'(1) : '0;
          if ((is_ld || is_st) && illegal) begin
            state_d    = RESP;
            mem_done_d = 1'b1;
            laf_d      = is_ld;
            saf_d      = is_st;
          end else if ((is_ld || is_st) && misal) begin
            state_d    = RESP;
            mem_done_d = 1'b1;
            lam_d      = is_ld;
            sam_d      = is_st;
          end else if (is_ld || is_st) begin
            state_d     = DACC;
            tmo_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = is_st;
            bus_addr_d  = {bus.MEM_ADDR[63:3], 3'b000};
            bus_wstrb_d = is_st ? (smask << bus.MEM_ADDR[2:0]) : 8'h00;
            bus_wdata_d = is_st ? (bus.MEM_WDATA << {bus.MEM_ADDR[2:0], 3'b000}) : 64'b0;
            ld_off_d    = bus.MEM_ADDR[2:0];
            ld_sz_d     = sz;
            ld_uns_d    = f3[2];
          end else begin
            state_d    = RESP;
            mem_done_d = 1'b1;
          end
        end else if (bus.IF_REQ) begin
          grant_cnt_d = '0;
          if (bus.IF_ADDR[1:0] != 2'b00) begin
            state_d    = RESP;
            if_done_d  = 1'b1;
            if_fault_d = 1'b1;
          end else begin
            state_d     = IFETCH;
            tmo_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_addr_d  = {bus.IF_ADDR[63:3], 3'b000};
            bus_wstrb_d = 8'h00;
            bus_wdata_d = 64'b0;
            if_hi_d     = bus.IF_ADDR[2];
          end
        end
      end
      DACC, IFETCH: begin
        tmo_d = tmo_q + TW'(1);
        if (xact_end) begin
          state_d     = RESP;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = 64'b0;
          bus_wstrb_d = 8'h00;
          bus_wdata_d = 64'b0;
          if (state_q == DACC) begin
            mem_done_d = 1'b1;
            laf_d      = xact_fault && !bus_we_q;
            saf_d      = xact_fault && bus_we_q;
            if (!xact_fault && !bus_we_q)
              mem_rdata_d = load_ext(bus.BUS_RDATA, ld_off_q, ld_sz_q, ld_uns_q);
          end else begin
            if_done_d  = 1'b1;
            if_fault_d = xact_fault;
            if (!xact_fault)
              if_rdata_d = if_hi_q ? bus.BUS_RDATA[63:32] : bus.BUS_RDATA[31:0];
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      grant_cnt_q <= '0;
      tmo_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 64'b0;
      bus_wstrb_q <= 8'h00;
      bus_wdata_q <= 64'b0;
      ld_off_q    <= 3'b0;
      ld_sz_q     <= 2'b0;
      ld_uns_q    <= 1'b0;
      if_hi_q     <= 1'b0;
      if_done_q   <= 1'b0;
      if_rdata_q  <= 32'b0;
      if_fault_q  <= 1'b0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= 64'b0;
      lam_q       <= 1'b0;
      laf_q       <= 1'b0;
      sam_q       <= 1'b0;
      saf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_cnt_q <= grant_cnt_d;
      tmo_q       <= tmo_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      ld_off_q    <= ld_off_d;
      ld_sz_q     <= ld_sz_d;
      ld_uns_q    <= ld_uns_d;
      if_hi_q     <= if_hi_d;
      if_done_q   <= if_done_d;
      if_rdata_q  <= if_rdata_d;
      if_fault_q  <= if_fault_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
      lam_q       <= lam_d;
      laf_q       <= laf_d;
      sam_q       <= sam_d;
      saf_q       <= saf_d;
    end
  end

  assign bus.IF_DONE   = if_done_q;
  assign bus.IF_RDATA  = if_rdata_q;
  assign bus.IF_FAULT  = if_fault_q;
  assign bus.MEM_DONE  = mem_done_q;
  assign bus.MEM_STALL = bus.MEM_REQ & ~mem_done_q;
  assign bus.MEM_RDATA = mem_rdata_q;
  assign bus.MEM_LAM   = lam_q;
  assign bus.MEM_LAF   = laf_q;
  assign bus.MEM_SAM   = sam_q;
  assign bus.MEM_SAF   = saf_q;
  assign bus.BUS_REQ   = bus_req_q;
  assign bus.BUS_WE    = bus_we_q;
  assign bus.BUS_ADDR  = bus_addr_q;
  assign bus.BUS_WSTRB = bus_wstrb_q;
  assign bus.BUS_WDATA = bus_wdata_q;
endmodule
